alarm_ring_scheduler: RTL and testbench

Sequences the alarm output once the time counter reaches the alarm setting. Handles ringing, snooze, dismiss and auto-off timeout. Sits between the time/alarm counters and the Alarm_On indicator/buzzer driver. Runs in the 5 MHz domain and uses a 1 Hz single-cycle pulse as its timebase.

---
 rtl/alarm_ring_scheduler_pkg.sv | 35 +++
 rtl/alarm_ring_scheduler_sec_down_counter.sv | 47 ++++
 rtl/alarm_ring_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_alarm_ring_scheduler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_ring_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alarm_ring_scheduler_pkg
// Description : Shared definitions for the alarm ring scheduler: the 2-bit
//               scheduler state encodings, the BCD HHMM field offsets and a
//               helper that compares a time word against the alarm setting.
// Revision    : 1.0 - initial release
// ============================================================================
package alarm_ring_scheduler_pkg;

    // Scheduler states
    localparam logic [1:0] c_state_idle     = 2'd0;
    localparam logic [1:0] c_state_ringing  = 2'd1;
    localparam logic [1:0] c_state_snoozing = 2'd2;
    localparam logic [1:0] c_state_lockout  = 2'd3;

    // BCD HHMM layout: [15:8] = hours (tens, ones), [7:0] = minutes (tens, ones)
    localparam int c_bcd_min_lsb  = 0;
    localparam int c_bcd_hour_lsb = 8;
    localparam int c_bcd_field_w  = 8;

    // True when the hours, minutes and AM/PM flag all agree.
    function automatic logic time_matches(
        input logic [15:0] time_bcd,
        input logic [15:0] alarm_bcd,
        input logic        time_pm,
        input logic        alarm_pm
    );
        return (time_bcd[c_bcd_hour_lsb +: c_bcd_field_w] == alarm_bcd[c_bcd_hour_lsb +: c_bcd_field_w])
            && (time_bcd[c_bcd_min_lsb  +: c_bcd_field_w] == alarm_bcd[c_bcd_min_lsb  +: c_bcd_field_w])
            && (time_pm == alarm_pm);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_ring_scheduler_sec_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : sec_down_counter
// Description : Loadable seconds down-counter. Decrements on a qualified
//               1 Hz pulse and never wraps below zero. o_last flags the value
//               1, i.e. the next decrement ends the interval.
// Ports       : i_Clk, i_Reset (async, active-high)
//               i_clear       - force count to 0 (highest priority)
//               i_load        - load i_load_value
//               i_load_value  - reload value
//               i_dec         - decrement request (one-cycle)
//               o_count       - current count
//               o_last        - count == 1
// Revision    : 1.0 - initial release
// ============================================================================
module sec_down_counter #(
    parameter int CNT_WIDTH = 10
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic                 i_clear,
    input  logic                 i_load,
    input  logic [CNT_WIDTH-1:0] i_load_value,
    input  logic                 i_dec,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_last
);

    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == CNT_WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/alarm_ring_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : alarm_ring_scheduler
// Description : Drives the alarm indicator once the time reaches the alarm
//               setting: ringing, limited snoozes, dismiss, and automatic
//               silence after a ring timeout. Timebase is a 1 Hz one-cycle
//               pulse in the 5 MHz clock domain.
// Ports       : i_Clk, i_Reset (async, active-high), i_Sec_Pulse,
//               i_Alarm_Enable, i_Time/i_Alarm_Time (BCD HHMM),
//               i_Time_PM/i_Alarm_PM, i_Snooze_Pulse, i_Dismiss_Pulse
//               o_Alarm_On, o_Snoozing, o_Snooze_Count (sat. 3),
//               o_Snooze_Remaining, o_Timed_Out (one-cycle pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_ring_scheduler
    import alarm_ring_scheduler_pkg::*;
#(
    parameter int SNOOZE_SECONDS       = 540,
    parameter int RING_TIMEOUT_SECONDS = 300,
    parameter int MAX_SNOOZES          = 3,
    parameter int CNT_WIDTH            = 10
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic                 i_Sec_Pulse,
    input  logic                 i_Alarm_Enable,
    input  logic [15:0]          i_Time,
    input  logic [15:0]          i_Alarm_Time,
    input  logic                 i_Time_PM,
    input  logic                 i_Alarm_PM,
    input  logic                 i_Snooze_Pulse,
    input  logic                 i_Dismiss_Pulse,
    output logic                 o_Alarm_On,
    output logic                 o_Snoozing,
    output logic [1:0]           o_Snooze_Count,
    output logic [CNT_WIDTH-1:0] o_Snooze_Remaining,
    output logic                 o_Timed_Out
);

    // Internal snooze tally is wide enough to compare against MAX_SNOOZES
    // and never below 3 bits so the saturating output decode is meaningful.
    localparam int c_used_w_raw = $clog2(MAX_SNOOZES + 2);
    localparam int c_used_w     = (c_used_w_raw < 3) ? 3 : c_used_w_raw;

    logic                 w_match;
    logic                 r_match_q;
    logic                 r_primed;
    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [CNT_WIDTH-1:0] r_ring_cnt;
    logic [CNT_WIDTH-1:0] w_ring_nxt;
    logic [c_used_w-1:0]  r_snooze_used;
    logic [c_used_w-1:0]  w_used_nxt;
    logic                 w_timeout;
    logic                 w_snz_load;
    logic                 w_snz_dec;
    logic                 w_snz_clear;
    logic                 w_snz_last;
    logic [1:0]           w_count_sat;

    logic                 r_alarm_on;
    logic                 r_snoozing;
    logic [1:0]           r_snooze_count;
    logic                 r_timed_out;

    assign w_match = i_Alarm_Enable & time_matches(i_Time, i_Alarm_Time, i_Time_PM, i_Alarm_PM);

    always_comb begin
        w_state_nxt = r_state;
        w_ring_nxt  = r_ring_cnt;
        w_used_nxt  = r_snooze_used;
        w_timeout   = 1'b0;
        w_snz_load  = 1'b0;
        w_snz_dec   = 1'b0;
        if (!i_Alarm_Enable) begin
            w_state_nxt = c_state_idle;
            w_ring_nxt  = '0;
            w_used_nxt  = '0;
        end else begin
            case (r_state)
                c_state_idle: begin
                    // r_primed blocks a match that was already present when
                    // reset released: only a genuine rising edge rings.
                    if (w_match && !r_match_q && r_primed) begin
                        w_state_nxt = c_state_ringing;
                        w_ring_nxt  = '0;
                        w_used_nxt  = '0;
                    end
                end
                c_state_ringing: begin
                    if (i_Dismiss_Pulse) begin
                        w_state_nxt = c_state_lockout;
                    end else if (i_Snooze_Pulse && (r_snooze_used < c_used_w'(MAX_SNOOZES))) begin
                        // A coincident second pulse is deliberately dropped.
                        w_state_nxt = c_state_snoozing;
                        w_snz_load  = 1'b1;
                        w_used_nxt  = r_snooze_used + c_used_w'(1);
                    end else if (i_Sec_Pulse) begin
                        if (r_ring_cnt == CNT_WIDTH'(RING_TIMEOUT_SECONDS - 1)) begin
                            w_state_nxt = c_state_lockout;
                            w_timeout   = 1'b1;
                        end else begin
                            w_ring_nxt = r_ring_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                c_state_snoozing: begin
                    if (i_Dismiss_Pulse) begin
                        w_state_nxt = c_state_lockout;
                    end else if (i_Sec_Pulse) begin
                        if (w_snz_last) begin
                            w_state_nxt = c_state_ringing;
                            w_ring_nxt  = '0;
                        end else begin
                            w_snz_dec = 1'b1;
                        end
                    end
                end
                c_state_lockout: begin
                    // Hold off until the alarm minute has passed.
                    if (!w_match) begin
                        w_state_nxt = c_state_idle;
                    end
                end
                default: w_state_nxt = c_state_idle;
            endcase
            if ((w_state_nxt == c_state_idle) || (w_state_nxt == c_state_lockout)) begin
                w_used_nxt = '0;
            end
        end
    end

    // Remaining time reads 0 whenever the next state is not a snooze.
    assign w_snz_clear = (w_state_nxt != c_state_snoozing);
    assign w_count_sat = (w_used_nxt > c_used_w'(3)) ? 2'd3 : w_used_nxt[1:0];

    sec_down_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_snooze_counter (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .i_clear      (w_snz_clear),
        .i_load       (w_snz_load),
        .i_load_value (CNT_WIDTH'(SNOOZE_SECONDS)),
        .i_dec        (w_snz_dec),
        .o_count      (o_Snooze_Remaining),
        .o_last       (w_snz_last)
    );

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state        <= c_state_idle;
            r_match_q      <= 1'b0;
            r_primed       <= 1'b0;
            r_ring_cnt     <= '0;
            r_snooze_used  <= '0;
            r_alarm_on     <= 1'b0;
            r_snoozing     <= 1'b0;
            r_snooze_count <= 2'd0;
            r_timed_out    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_match_q      <= w_match;
            r_primed       <= r_primed | ~w_match;
            r_ring_cnt     <= w_ring_nxt;
            r_snooze_used  <= w_used_nxt;
            r_alarm_on     <= (w_state_nxt == c_state_ringing);
            r_snoozing     <= (w_state_nxt == c_state_snoozing);
            r_snooze_count <= w_count_sat;
            r_timed_out    <= w_timeout;
        end
    end

    assign o_Alarm_On     = r_alarm_on;
    assign o_Snoozing     = r_snoozing;
    assign o_Snooze_Count = r_snooze_count;
    assign o_Timed_Out    = r_timed_out;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ring_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_ring_scheduler
// Description : Scoreboard bench for alarm_ring_scheduler. Each driven cycle
//               a behavioural model predicts the outputs after the next clock
//               edge and queues them; a monitor pops and compares on the
//               falling edge. Directed scenarios precede a random phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_ring_scheduler;

    localparam int SN = 5;
    localparam int TO = 4;
    localparam int MX = 2;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sec = 1'b0;
    logic          en  = 1'b0;
    logic [15:0]   tnow = 16'h0000;
    logic [15:0]   talm = 16'h0630;
    logic          tpm = 1'b0;
    logic          apm = 1'b0;
    logic          snz = 1'b0;
    logic          dis = 1'b0;

    logic          alarm_on;
    logic          snoozing;
    logic [1:0]    snz_count;
    logic [CW-1:0] snz_rem;
    logic          timed_out;

    always #5 clk = ~clk;

    alarm_ring_scheduler #(
        .SNOOZE_SECONDS       (SN),
        .RING_TIMEOUT_SECONDS (TO),
        .MAX_SNOOZES          (MX),
        .CNT_WIDTH            (CW)
    ) dut (
        .i_Clk              (clk),
        .i_Reset            (rst),
        .i_Sec_Pulse        (sec),
        .i_Alarm_Enable     (en),
        .i_Time             (tnow),
        .i_Alarm_Time       (talm),
        .i_Time_PM          (tpm),
        .i_Alarm_PM         (apm),
        .i_Snooze_Pulse     (snz),
        .i_Dismiss_Pulse    (dis),
        .o_Alarm_On         (alarm_on),
        .o_Snoozing         (snoozing),
        .o_Snooze_Count     (snz_count),
        .o_Snooze_Remaining (snz_rem),
        .o_Timed_Out        (timed_out)
    );

    typedef struct packed {
        logic          on;
        logic          snoozing;
        logic [1:0]    count;
        logic [CW-1:0] rem;
        logic          timed_out;
    } out_t;

    out_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // ---------------- behavioural model ----------------
    typedef enum { M_IDLE, M_RING, M_SNOOZE, M_LOCK } mode_e;
    mode_e m_mode;
    int    m_elapsed;   // seconds rung since ringing (re)started
    int    m_left;      // seconds left in the snooze
    int    m_used;      // snoozes taken this event
    bit    m_prev;      // match seen on the previous cycle

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_elapsed = 0;
        m_left    = 0;
        m_used    = 0;
        // A match already present at reset release must not count as an edge.
        m_prev    = 1'b1;
    endtask

    task automatic model_step(output out_t e);
        bit match;
        bit tmo;
        match = en && (tnow == talm) && (tpm == apm);
        tmo   = 1'b0;
        if (!en) begin
            m_mode = M_IDLE; m_used = 0; m_elapsed = 0; m_left = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (match && !m_prev) begin
                    m_mode = M_RING; m_elapsed = 0; m_used = 0;
                end
                M_RING: begin
                    if (dis) m_mode = M_LOCK;
                    else if (snz && m_used < MX) begin
                        m_mode = M_SNOOZE; m_left = SN; m_used++;
                    end else if (sec) begin
                        m_elapsed++;
                        if (m_elapsed >= TO) begin m_mode = M_LOCK; tmo = 1'b1; end
                    end
                end
                M_SNOOZE: begin
                    if (dis) m_mode = M_LOCK;
                    else if (sec) begin
                        m_left--;
                        if (m_left == 0) begin m_mode = M_RING; m_elapsed = 0; end
                    end
                end
                default: if (!match) m_mode = M_IDLE;
            endcase
        end
        m_prev      = match;
        e.on        = (m_mode == M_RING);
        e.snoozing  = (m_mode == M_SNOOZE);
        e.count     = ((m_mode == M_RING) || (m_mode == M_SNOOZE)) ? 2'((m_used > 3) ? 3 : m_used) : 2'd0;
        e.rem       = (m_mode == M_SNOOZE) ? CW'(m_left) : '0;
        e.timed_out = tmo;
    endtask

    // ---------------- driver helpers ----------------
    // Inputs are already set; predict, clock, then queue the prediction.
    task automatic cyc();
        out_t e;
        model_step(e);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        sec = 1'b0;
        snz = 1'b0;
        dis = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, want);
        end
    endtask

    // Outputs must fall without waiting for a clock edge.
    task automatic async_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_on",    32'(alarm_on),  32'd0);
        chk("async_rst_snz",   32'(snoozing),  32'd0);
        chk("async_rst_count", 32'(snz_count), 32'd0);
        chk("async_rst_rem",   32'(snz_rem),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        out_t e;
        out_t a;
        if (!rst && (exp_q.size() > 0)) begin
            e = exp_q.pop_front();
            a = {alarm_on, snoozing, snz_count, snz_rem, timed_out};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL outputs @%0t: got on=%0b snz=%0b cnt=%0d rem=%0d to=%0b want on=%0b snz=%0b cnt=%0d rem=%0d to=%0b",
                         $time, a.on, a.snoozing, a.count, a.rem, a.timed_out,
                         e.on, e.snoozing, e.count, e.rem, e.timed_out);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        en = 1'b1;
        tnow = 16'h0629;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_on",    32'(alarm_on),  32'd0);
        chk("reset_snz",   32'(snoozing),  32'd0);
        chk("reset_count", 32'(snz_count), 32'd0);
        chk("reset_rem",   32'(snz_rem),   32'd0);
        chk("reset_to",    32'(timed_out), 32'd0);
        rst = 1'b0;

        // 1: ring on the match edge, dismiss, lockout for the minute
        repeat (3) cyc();
        tnow = 16'h0630; cyc();
        repeat (2) cyc();
        dis = 1'b1; cyc();
        repeat (4) cyc();
        tnow = 16'h0631; repeat (3) cyc();

        // 2 and 3: snooze countdown, re-ring, snooze limit
        tnow = 16'h0630; cyc(); cyc();
        for (int k = 0; k < MX; k++) begin
            snz = 1'b1; cyc(); cyc();
            repeat (SN) begin sec = 1'b1; cyc(); cyc(); end
        end
        snz = 1'b1; cyc(); cyc();
        dis = 1'b1; cyc();
        tnow = 16'h0631; cyc(); cyc();

        // 4: ring timeout, no retrigger within the minute
        tnow = 16'h0630; cyc();
        repeat (TO) begin sec = 1'b1; cyc(); cyc(); end
        repeat (5) cyc();
        tnow = 16'h0631; cyc(); cyc();

        // 5: coincident snooze+dismiss, then snooze+sec pulse
        tnow = 16'h0630; cyc(); cyc();
        snz = 1'b1; dis = 1'b1; cyc(); cyc();
        tnow = 16'h0631; cyc();
        tnow = 16'h0630; cyc(); cyc();
        snz = 1'b1; sec = 1'b1; cyc(); cyc(); cyc();

        // 6: enable drop mid-snooze, re-arm in the minute, reset mid-ring
        en = 1'b0; cyc(); cyc();
        en = 1'b1; cyc(); cyc();
        async_reset();
        repeat (3) cyc();
        tnow = 16'h0631; cyc();
        tnow = 16'h0630; cyc(); cyc();
        dis = 1'b1; cyc();

        // Random phase around the alarm minute
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 4))
                    0, 1:    tnow = talm;
                    2:       tnow = 16'h0629;
                    3:       tnow = 16'h0631;
                    default: tnow = 16'h1630;
                endcase
                tpm = ($urandom_range(0, 7) == 0);
            end
            en  = ($urandom_range(0, 49) != 0);
            sec = ($urandom_range(0, 3) == 0);
            snz = ($urandom_range(0, 9) == 0);
            dis = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 599) == 0) begin
                sec = 1'b0; snz = 1'b0; dis = 1'b0;
                async_reset();
            end else begin
                cyc();
            end
        end

        @(negedge clk);
        #1;
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
